wb_arbiter_2m: RTL



---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wishbone_p_if.sv | 21 ++
 rtl/wb_arbiter_2m.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter and its bus interface.
package wb_arb_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = WB_DW / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT0  = 2'd1,
      GNT1  = 2'd2,
      ABORT = 2'd3
   } arb_state_e;

   // Bits needed to hold a counter running 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wishbone_p_if.sv
// Pipelined Wishbone bundle. dat_i carries write data towards the slave, dat_o read data back.
interface wishbone_p_if;

   logic                         cyc;
   logic                         stb;
   logic                         we;
   logic [wb_arb_pkg::WB_AW-1:0] adr;
   logic [wb_arb_pkg::WB_SW-1:0] sel;
   logic [wb_arb_pkg::WB_DW-1:0] dat_i;
   logic [wb_arb_pkg::WB_DW-1:0] dat_o;
   logic                         ack;
   logic                         err;
   logic                         stall;

   modport master (output cyc, stb, we, adr, sel, dat_i,
                   input  dat_o, ack, err, stall);

   modport slave  (input  cyc, stb, we, adr, sel, dat_i,
                   output dat_o, ack, err, stall);

endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with bus lock, outstanding limit and hung-cycle abort.
//
// state | meaning
// IDLE  | no grant; slave bus idle, both masters stalled
// GNT0  | master 0 owns the slave until it drops cyc
// GNT1  | master 1 owns the slave until it drops cyc
// ABORT | timed-out cycle; wait for the aborted master (last) to drop cyc
module wb_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT         = 255
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   wishbone_p_if.slave  m0,
   wishbone_p_if.slave  m1,
   wishbone_p_if.master s
);

   localparam int            OW        = cnt_width(MAX_OUTSTANDING);
   localparam int            TW        = cnt_width(TIMEOUT);
   localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

   arb_state_e    state, state_nxt;
   logic          last;
   logic [OW-1:0] outst, outst_nxt;
   logic [TW-1:0] tmo, tmo_nxt;

   logic             granted, gnt_sel, tmo_hit, pass, full;
   logic             g_cyc, g_stb, g_we;
   logic [WB_AW-1:0] g_adr;
   logic [WB_SW-1:0] g_sel;
   logic [WB_DW-1:0] g_dat;
   logic             stb_out, accept, resp;
   logic             rsp_ack, rsp_err, rsp_stall;
   logic [WB_DW-1:0] rsp_dat;

   // Grant qualifiers and the request-side two-way mux.
   always_comb begin
      granted = (state == GNT0) || (state == GNT1);
      gnt_sel = (state == GNT1);
      tmo_hit = (TIMEOUT != 0) && granted && (tmo == TMO_LIMIT);
      pass    = granted && !tmo_hit;
      full    = (outst == OUTST_MAX);
      g_cyc   = gnt_sel ? m1.cyc   : m0.cyc;
      g_stb   = gnt_sel ? m1.stb   : m0.stb;
      g_we    = gnt_sel ? m1.we    : m0.we;
      g_adr   = gnt_sel ? m1.adr   : m0.adr;
      g_sel   = gnt_sel ? m1.sel   : m0.sel;
      g_dat   = gnt_sel ? m1.dat_i : m0.dat_i;
      stb_out = pass && g_cyc && g_stb && !full;
      accept  = stb_out && !s.stall;
      resp    = pass && g_cyc && (s.ack || s.err);
   end

   // Bus steering: granted master passes straight through, everyone else sees stall and no response.
   always_comb begin
      s.cyc   = pass && g_cyc;
      s.stb   = stb_out;
      s.we    = pass && g_we;
      s.adr   = pass ? g_adr : '0;
      s.sel   = pass ? g_sel : '0;
      s.dat_i = pass ? g_dat : '0;

      // Responses after the master dropped cyc belong to an abandoned cycle and are swallowed.
      rsp_ack   = pass && g_cyc && s.ack;
      rsp_err   = tmo_hit || (pass && g_cyc && s.err);
      rsp_stall = !pass || s.stall || full;
      rsp_dat   = pass ? s.dat_o : '0;

      m0.ack   = granted && !gnt_sel && rsp_ack;
      m0.err   = granted && !gnt_sel && rsp_err;
      m0.stall = (granted && !gnt_sel) ? rsp_stall : 1'b1;
      m0.dat_o = (granted && !gnt_sel) ? rsp_dat : '0;
      m1.ack   = granted && gnt_sel && rsp_ack;
      m1.err   = granted && gnt_sel && rsp_err;
      m1.stall = (granted && gnt_sel) ? rsp_stall : 1'b1;
      m1.dat_o = (granted && gnt_sel) ? rsp_dat : '0;
   end

   // Next-state: round-robin on ties, hold grant while cyc stays high, abort on timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0.cyc && m1.cyc) state_nxt = last ? GNT0 : GNT1;
            else if (m0.cyc)      state_nxt = GNT0;
            else if (m1.cyc)      state_nxt = GNT1;
         end
         GNT0: begin
            if (tmo_hit)      state_nxt = ABORT;
            else if (!m0.cyc) state_nxt = m1.cyc ? GNT1 : IDLE;
         end
         GNT1: begin
            if (tmo_hit)      state_nxt = ABORT;
            else if (!m1.cyc) state_nxt = m0.cyc ? GNT0 : IDLE;
         end
         ABORT: begin
            if (!(last ? m1.cyc : m0.cyc)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outstanding and timeout counters; both collapse to zero whenever no live granted cycle exists.
   always_comb begin
      outst_nxt = outst;
      if (!pass || !g_cyc)                      outst_nxt = '0;
      else if (accept && !resp)                 outst_nxt = outst + 1'b1;
      else if (resp && !accept && outst != '0)  outst_nxt = outst - 1'b1;

      tmo_nxt = '0;
      if ((TIMEOUT != 0) && pass && g_cyc && (outst != '0) && !resp) tmo_nxt = tmo + 1'b1;
   end

   // State, round-robin pointer and counters; last starts at 1 so m0 wins the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         last  <= 1'b1;
         outst <= '0;
         tmo   <= '0;
      end else begin
         state <= state_nxt;
         outst <= outst_nxt;
         tmo   <= tmo_nxt;
         if (state_nxt == GNT0)      last <= 1'b0;
         else if (state_nxt == GNT1) last <= 1'b1;
      end
   end

endmodule
